// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer.
// The PAR state is only reached when PISO_PARITY_EN is defined.
package piso_pkg;

    localparam int PISO_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for the serializer: counts 0..WIDTH-1, saturates at
// the terminal count and flags it with tc. Build option PISO_PARITY_EN has no effect here.
module piso_bit_cnt #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with ready/valid load and shift_en stall.
// Define PISO_PARITY_EN to append one even-parity bit after each word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH_DEF,
    parameter int MSB_FIRST = 0,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             q,
    output logic             q_valid,
    output logic             last,
    output logic             done
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic             done_q;
    logic             done_d;

    logic [CW-1:0]    cnt;
    logic             tc;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             capture;
    logic             word_end;
    logic [WIDTH-1:0] tx_order;

    // Reorder the shadow word so that the counter always indexes transmit order.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
        if (MSB_FIRST != 0) begin : g_msb
            assign tx_order[gi] = shadow_q[WIDTH-1-gi];
        end else begin : g_lsb
            assign tx_order[gi] = shadow_q[gi];
        end
    end

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        q        = 1'b0;
        q_valid  = 1'b0;
        last     = 1'b0;

        case (state_q)
            SHIFT: begin
                q       = tx_order[cnt];
                q_valid = 1'b1;
`ifdef PISO_PARITY_EN
                last    = 1'b0;
`else
                last    = tc;
`endif
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                q       = ^shadow_q;
                q_valid = 1'b1;
                last    = 1'b1;
            end
`endif
            default: ;
        endcase

        word_end   = last && shift_en;
        load_ready = !reset && ((state_q == IDLE) || word_end);
        capture    = load_valid && load_ready;
        cnt_clr    = capture || word_end;
        cnt_inc    = (state_q == SHIFT) && shift_en;

        if (capture) begin
            // Covers both a load from IDLE and a back-to-back load on the final bit.
            state_d  = SHIFT;
            shadow_d = load_data;
        end else if (word_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef PISO_PARITY_EN
        end else if ((state_q == SHIFT) && tc && shift_en) begin
            state_d = PAR;
`endif
        end else if ((state_q != IDLE) && (state_q != SHIFT)
`ifdef PISO_PARITY_EN
                     && (state_q != PAR)
`endif
                    ) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (LSB-first and MSB-first
// instances side by side); expectations adapt when PISO_PARITY_EN is defined.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         shift_en;

    logic load_ready_a, q_a, q_valid_a, last_a, done_a;
    logic load_ready_b, q_b, q_valid_b, last_b, done_b;
    logic o_rdy, o_q, o_v, o_l, o_d;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_a),
        .shift_en   (shift_en),
        .q          (q_a),
        .q_valid    (q_valid_a),
        .last       (last_a),
        .done       (done_a)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready_b),
        .shift_en   (shift_en),
        .q          (q_b),
        .q_valid    (q_valid_b),
        .last       (last_b),
        .done       (done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic obs(input bit msb);
        if (msb) begin
            o_rdy = load_ready_b; o_q = q_b; o_v = q_valid_b; o_l = last_b; o_d = done_b;
        end else begin
            o_rdy = load_ready_a; o_q = q_a; o_v = q_valid_a; o_l = last_a; o_d = done_a;
        end
    endtask

    // seq[7] is the first bit on the wire; par is the hand-computed parity bit.
    function automatic logic exp_bit(input logic [7:0] seq, input logic par, input int i);
        if (i < W) return seq[7-i];
        return par;
    endfunction

    // Checks NB serial bits; optionally stalls shift_en for 3 edges at bit stall_at.
    task automatic shift_bits(input string tag, input logic [7:0] seq, input logic par,
                              input bit msb, input int stall_at);
        for (int i = 0; i < NB; i++) begin
            obs(msb);
            check($sformatf("%s.valid[%0d]", tag, i), o_v, 1);
            check($sformatf("%s.q[%0d]", tag, i), o_q, exp_bit(seq, par, i));
            check($sformatf("%s.last[%0d]", tag, i), o_l, (i == NB-1));
            check($sformatf("%s.done[%0d]", tag, i), o_d, 0);
            check($sformatf("%s.ready[%0d]", tag, i), o_rdy, (i == NB-1));
            if (i == stall_at) begin
                shift_en = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    load_valid = (k == 1);
                    load_data  = 8'hAA;
                    tick();
                    obs(msb);
                    check($sformatf("%s.stall_q[%0d]", tag, k), o_q, exp_bit(seq, par, i));
                    check($sformatf("%s.stall_valid[%0d]", tag, k), o_v, 1);
                    check($sformatf("%s.stall_last[%0d]", tag, k), o_l, 0);
                    check($sformatf("%s.stall_ready[%0d]", tag, k), o_rdy, 0);
                end
                load_valid = 1'b0;
                shift_en   = 1'b1;
            end
            tick();
        end
    endtask

    task automatic idle_after(input string tag, input bit msb, input bit exp_done);
        obs(msb);
        check({tag, ".end_valid"}, o_v, 0);
        check({tag, ".end_q"}, o_q, 0);
        check({tag, ".end_done"}, o_d, exp_done);
        check({tag, ".end_ready"}, o_rdy, 1);
        tick();
        obs(msb);
        check({tag, ".done_gone"}, o_d, 0);
        check({tag, ".still_idle"}, o_v, 0);
    endtask

    task automatic run_word(input string tag, input logic [7:0] data, input logic [7:0] seq,
                            input logic par, input bit msb, input int stall_at);
        obs(msb);
        check({tag, ".ready0"}, o_rdy, 1);
        load_valid = 1'b1;
        load_data  = data;
        tick();
        load_valid = 1'b0;
        load_data  = ~data;
        shift_bits(tag, seq, par, msb, stall_at);
        idle_after(tag, msb, 1'b1);
        $display("word %s data=%02h msb_first=%0d bits=%0d", tag, data, msb, NB);
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        shift_en   = 1'b1;
        tick();
        tick();
        obs(0);
        check("rst.q", o_q, 0);
        check("rst.valid", o_v, 0);
        check("rst.last", o_l, 0);
        check("rst.done", o_d, 0);
        check("rst.ready", o_rdy, 0);
        reset = 1'b0;
        #1;
        obs(0);
        check("rst.ready_after", o_rdy, 1);
        $display("reset sequence complete");

        run_word("basic_a5", 8'hA5, 8'b10100101, 1'b0, 1'b0, -1);
        run_word("msb_a5", 8'hA5, 8'b10100101, 1'b0, 1'b1, -1);
        run_word("msb_01", 8'h01, 8'b00000001, 1'b1, 1'b1, -1);

        // Back-to-back: FF then 00 held on load_valid through word 1.
        load_valid = 1'b1;
        load_data  = 8'hFF;
        tick();
        load_data  = 8'h00;
        shift_bits("b2b_ff", 8'hFF, 1'b0, 1'b0, -1);
        load_valid = 1'b0;
        shift_bits("b2b_00", 8'h00, 1'b0, 1'b0, -1);
        idle_after("b2b", 1'b0, 1'b1);
        $display("word b2b data=ff,00 bits=%0d", 2*NB);

        run_word("stall_f0", 8'hF0, 8'b00001111, 1'b0, 1'b0, 2);

        // Reset mid-word with load_valid also high: reset must win.
        load_valid = 1'b1;
        load_data  = 8'h3C;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs(0);
            check($sformatf("rst3c.q[%0d]", i), o_q, exp_bit(8'b00111100, 1'b0, i));
            tick();
        end
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h55;
        tick();
        reset      = 1'b0;
        load_valid = 1'b0;
        #1;
        obs(0);
        check("rst3c.valid", o_v, 0);
        check("rst3c.q", o_q, 0);
        check("rst3c.done", o_d, 0);
        check("rst3c.last", o_l, 0);
        check("rst3c.ready", o_rdy, 1);
        $display("word rst3c data=3c aborted by reset");

        run_word("after_rst_81", 8'h81, 8'b10000001, 1'b0, 1'b0, -1);
        run_word("par_07", 8'h07, 8'b11100000, 1'b1, 1'b0, -1);
        run_word("par_a5", 8'hA5, 8'b10100101, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per word (>= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 0:
- 0: bit 0 is transmitted first.
- 1: bit WIDTH-1 is transmitted first.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 load_valid  in  1  load_data is presented for capture.
REQ-006 load_data  in  WIDTH  parallel word to serialize.
REQ-007 load_ready  out  1  block can capture a word this cycle.
REQ-008 shift_en  in  1  advance to the next bit; low = hold the current bit.
REQ-009 q  out  1  serial data out.
REQ-010 q_valid  out  1  q carries a valid bit.
REQ-011 last  out  1  q carries the final bit of the word.
REQ-012 done  out  1  one-cycle pulse after a word completes with no follow-on word.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and PAR (PAR only when PISO_PARITY_EN is defined).
REQ-014 Handshake: a word SHALL be captured on an edge where load_valid && load_ready.
- load_valid while load_ready=0 is ignored; the word is not queued.
REQ-015 load_ready SHALL be 1 in IDLE.
- Also 1 when last && shift_en (back-to-back load).
- 0 otherwise, and 0 while reset=1.
REQ-016 Latency: after the capture edge, q_valid=1 and q = first bit in the very next cycle (1-cycle latency).
REQ-017 In SHIFT, each edge with shift_en=1 SHALL advance one bit; with shift_en=0, q, q_valid and last SHALL hold.
REQ-018 The bit counter SHALL count 0..WIDTH-1 and SHALL not wrap within a word.
- last=1 exactly when the final data bit is on q (no parity), or when the parity bit is on q (parity).
REQ-019 Final bit consumed (last && shift_en):
- If a new word is captured on the same edge, go to SHIFT with the counter reset to 0; no idle gap, and done stays 0.
- Otherwise go to IDLE; q_valid=0, q=0, and done=1 for exactly one cycle.
REQ-020 The captured word SHALL be held in an internal shadow register.
- Changes on load_data after capture SHALL NOT affect the output.
REQ-021 If reset and load_valid are asserted together, reset SHALL win; no word is captured.

Reset
REQ-022 On an edge with reset=1: state=IDLE, counter=0, q=0, q_valid=0, last=0, done=0, shadow register=0.
REQ-023 Reset mid-word SHALL discard the in-flight word; the next edge with reset=0 SHALL present load_ready=1.

Configuration
REQ-024 Macro PISO_PARITY_EN:
- Defined: after the WIDTH data bits, the FSM SHALL enter PAR and emit one even-parity bit (XOR of the captured word) with last=1, so each word takes WIDTH+1 bits.
- Undefined: the PAR state and parity logic SHALL be absent, and each word takes WIDTH bits.

Structure
REQ-025 Package piso_pkg SHALL hold:
- the state enum typedef (IDLE, SHIFT, PAR);
- the default-width constant PISO_WIDTH_DEF = 8.
REQ-026 The bit counter with its terminal-count flag SHALL be the sub-module piso_bit_cnt (parameter WIDTH; inputs clk, reset, clr, inc; outputs cnt, tc). The FSM and shadow register stay in the top module.

Verification
REQ-027 Basic word: WIDTH=8, MSB_FIRST=0, load 8'hA5, shift_en=1 -> q = 1,0,1,0,0,1,0,1 on consecutive cycles, last on the 8th bit, done pulse the cycle after.
REQ-028 MSB-first: MSB_FIRST=1, load 8'hA5 -> q = 1,0,1,0,0,1,0,1 (symmetric word); then load 8'h01 -> q = 0,0,0,0,0,0,0,1.
REQ-029 Back-to-back: load 8'hFF, then hold load_valid with 8'h00 -> load_ready=1 only on the last-bit cycle; 16 consecutive valid bits (eight 1s, eight 0s); exactly one done pulse, after word 2.
REQ-030 Stall: load 8'hF0 and drop shift_en for 3 cycles after bit 2 -> q holds 0 for those cycles; all 8 bits still delivered in order; load_valid pulses while busy are ignored.
REQ-031 Reset mid-word: load 8'h3C, assert reset after bit 4 -> next cycle q_valid=0, q=0, done=0, load_ready=1; a new load of 8'h81 serializes correctly.
REQ-032 Parity (PISO_PARITY_EN defined): load 8'h07 -> 8 data bits, then parity bit 1 with last=1; load 8'hA5 -> parity bit 0.
